// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ
// requesters. Each requester owns a one-entry registered response slot.
module regfile_read_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*5-1:0]  req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [4:0]            rf_sel,
  input  logic [31:0]           rf_rdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [NUM_REQ*32-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][31:0]     rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]           elig;
  logic                         gnt_found;
  logic [PW-1:0]                gnt_idx;
  logic [PW-1:0]                scan_idx;

  // A requester is eligible when its slot is empty or is being drained now
  always_comb begin
    elig = req_valid & (~rsp_valid_q | rsp_ready);
  end

  // Scan from rr_ptr upward with wraparound; first eligible requester wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && elig[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Grant outputs, forced idle while reset is asserted
  always_comb begin
    req_ready = '0;
    rf_sel    = '0;
    if (!rst && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
      rf_sel             = req_addr[5*gnt_idx +: 5];
    end
    busy = |req_ready;
  end

  // Slot drain, refill on grant (refill wins over drain), pointer advance
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_found) begin
      rsp_valid_d[gnt_idx] = 1'b1;
      rsp_data_d[gnt_idx]  = (ZERO_REG && rf_sel == 5'd0) ? 32'd0 : rf_rdata;
      rr_ptr_d             = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed self-checking bench for regfile_read_arbiter (NUM_REQ=4).
// A second instance with ZERO_REG=0 shares all inputs for the x0 check.
module tb_regfile_read_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [3:0]   req_ready, req_ready_nz;
  logic [4:0]   rf_sel, rf_sel_nz;
  logic [31:0]  rf_rdata;
  logic [3:0]   rsp_valid, rsp_valid_nz;
  logic [127:0] rsp_data, rsp_data_nz;
  logic [3:0]   rsp_ready;
  logic         busy, busy_nz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_read_arbiter #(.NUM_REQ(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rf_sel(rf_sel), .rf_rdata(rf_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  regfile_read_arbiter #(.NUM_REQ(4), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_nz), .rf_sel(rf_sel_nz), .rf_rdata(rf_rdata),
    .rsp_valid(rsp_valid_nz), .rsp_data(rsp_data_nz), .rsp_ready(rsp_ready),
    .busy(busy_nz)
  );

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0; rsp_ready = '0; req_addr = '0; rf_rdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'hF; rsp_ready = '0; rf_rdata = 32'h5555AAAA;
    req_addr = {5'd4, 5'd3, 5'd2, 5'd9};
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rf_sel !== 5'd0) begin errors++; $display("FAIL reset_rf_sel got=%0d exp=0", rf_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (rsp_data !== 128'd0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    checks++; if (rf_sel !== 5'd9) begin errors++; $display("FAIL reset_first_sel got=%0d exp=9", rf_sel); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL reset_first_rsp got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_data[31:0] !== 32'h5555AAAA) begin errors++; $display("FAIL reset_first_data got=%h exp=5555aaaa", rsp_data[31:0]); end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_addr[14:10] = 5'd5; rf_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    checks++; if (rf_sel !== 5'd5) begin errors++; $display("FAIL single_sel got=%0d exp=5", rf_sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_data[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp_data got=%h exp=deadbeef", rsp_data[95:64]); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_full_blocks got=%b exp=0000", req_ready); end
    // drain slot 2, then all request: pointer must now be at 3
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 4'b0100;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_drain_hold got=%h exp=deadbeef", rsp_data[95:64]); end
    @(negedge clk);
    req_valid = 4'hF; rsp_ready = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL single_rr_ptr3 got=%b exp=1000", req_ready); end
    req_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [4:0] exp_sel;
    do_reset();
    @(negedge clk);
    req_valid = 4'hF; rsp_ready = 4'hF; rf_rdata = 32'hA5A5_0000;
    req_addr = {5'd11, 5'd10, 5'd9, 5'd8};
    for (int c = 0; c < 5; c++) begin
      exp_g   = 4'b0001 << (c % 4);
      exp_sel = 5'(8 + (c % 4));
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
      checks++; if (rf_sel !== exp_sel) begin errors++; $display("FAIL rr_sel c=%0d got=%0d exp=%0d", c, rf_sel, exp_sel); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== exp_g) begin errors++; $display("FAIL rr_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_g); end
      @(negedge clk);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_addr[9:5] = 5'd7; req_addr[4:0] = 5'd2; rf_rdata = 32'h1111_0001;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_fill got=%b exp=0010", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_fill_rsp got=%b exp=0010", rsp_valid); end
    @(negedge clk);
    req_valid = 4'b0011; rsp_ready = 4'b0001; rf_rdata = 32'h3333_0003;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_blocked c=%0d got=%b exp=0001", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 4'b0011) begin errors++; $display("FAIL bp_rsp c=%0d got=%b exp=0011", c, rsp_valid); end
      @(negedge clk);
    end
    checks++; if (rsp_data[63:32] !== 32'h1111_0001) begin errors++; $display("FAIL bp_hold got=%h exp=11110001", rsp_data[63:32]); end
    rsp_ready = 4'b0011; rf_rdata = 32'h2222_0002;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
    checks++; if (rf_sel !== 5'd7) begin errors++; $display("FAIL bp_release_sel got=%0d exp=7", rf_sel); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_refill_valid got=%b exp=0010", rsp_valid); end
    checks++; if (rsp_data[63:32] !== 32'h2222_0002) begin errors++; $display("FAIL bp_refill_data got=%h exp=22220002", rsp_data[63:32]); end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_addr[4:0] = 5'd0; rf_rdata = 32'h12345678;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL x0_grant got=%b exp=0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_data[31:0] !== 32'd0) begin errors++; $display("FAIL x0_zero got=%h exp=00000000", rsp_data[31:0]); end
    checks++; if (rsp_data_nz[31:0] !== 32'h12345678) begin errors++; $display("FAIL x0_nozero got=%h exp=12345678", rsp_data_nz[31:0]); end
    // simultaneous drain and refill of slot 0 with a non-zero address
    @(negedge clk);
    req_addr[4:0] = 5'd3; rf_rdata = 32'hABCD0003; rsp_ready = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL x0_refill_grant got=%b exp=0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL x0_refill_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_data[31:0] !== 32'hABCD0003) begin errors++; $display("FAIL x0_refill_data got=%h exp=abcd0003", rsp_data[31:0]); end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge clk);
    req_valid = 4'b1010; rsp_ready = 4'b0000; rf_rdata = 32'h0F0F0F0F;
    req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b1010) begin errors++; $display("FAIL mid_fill got=%b exp=1010", rsp_valid); end
    @(negedge clk);
    req_valid = 4'h0;
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_async_clear got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data !== 128'd0) begin errors++; $display("FAIL mid_data_clear got=%h exp=0", rsp_data); end
    rst = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    req_valid = 4'h0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; rf_rdata = '0; rsp_ready = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_x0();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
